// File: rtl/loa_mon_pkg.sv
// Shared types and width helpers for approximate-adder accuracy monitors.
// Widths derive from operand width W and window size 2**WIN_LOG2.
package loa_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } mon_state_e;

  function automatic int ed_w(input int w);
    return w + 1;
  endfunction

  function automatic int cnt_w(input int win_log2);
    return win_log2 + 1;
  endfunction

  // Sum of N error distances, each below 2**(W+1), fits in W+1+WIN_LOG2 bits.
  function automatic int sum_w(input int w, input int win_log2);
    return w + 1 + win_log2;
  endfunction

endpackage

// File: rtl/loa_ed_calc.sv
// Error distance between the exact sum a+b and an approximate sum y.
// Purely combinational; no latency, no flow control.
module loa_ed_calc
  import loa_mon_pkg::*;
#(
  parameter int W = 6
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W:0]   y,
  output logic [W:0]   ed,
  output logic         ed_nz
);

  localparam int EW = ed_w(W);

  logic [EW-1:0] exact;
  logic [EW:0]   diff;

  always_comb begin
    exact = {1'b0, a} + {1'b0, b};
    diff  = {1'b0, exact} - {1'b0, y};
    // Sign bit of the widened difference selects which way to subtract.
    ed    = diff[EW] ? (y - exact) : diff[EW-1:0];
    ed_nz = |ed;
  end

endmodule

// File: rtl/loa_error_monitor.sv
// Accumulates error-distance statistics of an approximate adder over 2**WIN_LOG2 samples.
// Sample-to-accumulator latency 2 cycles; in_ready is registered, report held until rpt_ready.
module loa_error_monitor
  import loa_mon_pkg::*;
#(
  parameter int W        = 6,
  parameter int P        = 4,
  parameter int WIN_LOG2 = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        in_a,
  input  logic [W-1:0]        in_b,
  input  logic [W:0]          in_y,
  output logic                rpt_valid,
  input  logic                rpt_ready,
  output logic [WIN_LOG2:0]   rpt_samples,
  output logic [WIN_LOG2:0]   rpt_errcnt,
  output logic [W+WIN_LOG2:0] rpt_sum_ed,
  output logic [W:0]          rpt_max_ed,
  output logic                busy
);

  localparam int EW = ed_w(W);
  localparam int CW = cnt_w(WIN_LOG2);
  localparam int SW = sum_w(W, WIN_LOG2);
  localparam logic [CW-1:0] LAST = CW'((1 << WIN_LOG2) - 1);

  if (P > W) begin : g_bad_p
    $error("loa_error_monitor: P must not exceed W");
  end

  mon_state_e    state_q, state_d;
  logic          drain_q;
  logic [CW-1:0] cnt_q;
  logic          s1_vld;
  logic [EW-1:0] s1_ed;
  logic          s1_nz;
  logic [CW-1:0] acc_err;
  logic [SW-1:0] acc_sum;
  logic [EW-1:0] acc_max;
  logic [EW-1:0] ed;
  logic          ed_nz;
  logic          accept;
  logic          win_start;
  logic          win_done;

  loa_ed_calc #(.W(W)) u_ed_calc (
    .a     (in_a),
    .b     (in_b),
    .y     (in_y),
    .ed    (ed),
    .ed_nz (ed_nz)
  );

  assign accept    = in_valid & in_ready & ~abort;
  assign win_start = (state_q == IDLE) & start & ~abort;
  assign win_done  = (state_q == DRAIN) & drain_q & ~abort;
  assign rpt_valid = (state_q == REPORT);
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && cnt_q == LAST) state_d = DRAIN;
      DRAIN:   if (drain_q) state_d = REPORT;
      REPORT:  if (rpt_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready    <= 1'b0;
      drain_q     <= 1'b0;
      cnt_q       <= '0;
      s1_vld      <= 1'b0;
      s1_ed       <= '0;
      s1_nz       <= 1'b0;
      acc_err     <= '0;
      acc_sum     <= '0;
      acc_max     <= '0;
      rpt_samples <= '0;
      rpt_errcnt  <= '0;
      rpt_sum_ed  <= '0;
      rpt_max_ed  <= '0;
    end else begin
      state_q  <= state_d;
      // Registered from the next state, so the Nth accept drops it on the same edge.
      in_ready <= (state_d == RUN);
      drain_q  <= (state_q == DRAIN) & ~drain_q & ~abort;
      s1_vld   <= accept;
      if (accept) begin
        s1_ed <= ed;
        s1_nz <= ed_nz;
      end

      if (abort || win_start) begin
        cnt_q   <= '0;
        acc_err <= '0;
        acc_sum <= '0;
        acc_max <= '0;
      end else begin
        if (accept) cnt_q <= cnt_q + 1'b1;
        if (s1_vld) begin
          acc_err <= acc_err + CW'(s1_nz);
          acc_sum <= acc_sum + SW'(s1_ed);
          if (s1_ed > acc_max) acc_max <= s1_ed;
        end
      end

      if (win_start) begin
        rpt_samples <= '0;
        rpt_errcnt  <= '0;
        rpt_sum_ed  <= '0;
        rpt_max_ed  <= '0;
      end else if (win_done) begin
        rpt_samples <= cnt_q;
        rpt_errcnt  <= acc_err;
        rpt_sum_ed  <= acc_sum;
        rpt_max_ed  <= acc_max;
      end
    end
  end

endmodule
